// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter: round-robin arbiter that shares a bank of NFF JK cells
// between NREQ command sources. A winning command is captured into a
// one-deep stage register and applied to its cell on the following edge.
// Optional build macro: JK_ARB_ASSERT_EN compiles in concurrent SVA checks.
module jk_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  localparam int AW  = $clog2(NFF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  cmd,
  input  logic [AW*NREQ-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic               upd_vld,
  output logic [AW-1:0]      upd_addr,
  output logic [NFF-1:0]     q,
  output logic [NFF-1:0]     q_bar
);

  localparam int unsigned NREQ_U = NREQ;
  localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            stage_vld_q, stage_vld_d;
  jk_cmd_e         stage_cmd_q, stage_cmd_d;
  logic [AW-1:0]   stage_addr_q, stage_addr_d;
  logic [NFF-1:0]  q_q, q_d;
  logic            upd_vld_q, upd_vld_d;
  logic [AW-1:0]   upd_addr_q, upd_addr_d;

  logic [1:0]      cmd_a  [NREQ];
  logic [AW-1:0]   addr_a [NREQ];
  logic [NREQ-1:0] elig;
  logic            win_vld;
  logic [PW-1:0]   win_idx;
  int unsigned     cand;

  // Split the flat per-requester command/address buses into arrays.
  always_comb begin
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      cmd_a[i]  = cmd[2*i +: 2];
      addr_a[i] = addr[AW*i +: AW];
    end
  end

  // Round-robin search from ptr; a requester holding gnt this cycle is skipped.
  always_comb begin
    elig    = req & ~gnt_q;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned off = 0; off < NREQ_U; off++) begin
      cand = (32'(ptr_q) + off) % NREQ_U;
      if (!win_vld && elig[PW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  // Grant, stage capture and pointer advance for the next edge.
  always_comb begin
    gnt_d        = '0;
    stage_vld_d  = win_vld;
    stage_cmd_d  = stage_cmd_q;
    stage_addr_d = stage_addr_q;
    ptr_d        = ptr_q;
    if (win_vld) begin
      gnt_d[win_idx] = 1'b1;
      stage_cmd_d    = jk_cmd_e'(cmd_a[win_idx]);
      stage_addr_d   = addr_a[win_idx];
      ptr_d          = (win_idx == PW'(NREQ_U - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // JK update of the staged cell; other cells keep their value.
  always_comb begin
    q_d        = q_q;
    upd_vld_d  = stage_vld_q;
    upd_addr_d = upd_addr_q;
    if (stage_vld_q) begin
      upd_addr_d = stage_addr_q;
      unique case (stage_cmd_q)
        JK_HOLD:   q_d[stage_addr_q] = q_q[stage_addr_q];
        JK_RESET:  q_d[stage_addr_q] = 1'b0;
        JK_SET:    q_d[stage_addr_q] = 1'b1;
        JK_TOGGLE: q_d[stage_addr_q] = ~q_q[stage_addr_q];
      endcase
    end
  end

  // Arbiter state: grant pulse, stage register, round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q        <= '0;
      ptr_q        <= '0;
      stage_vld_q  <= 1'b0;
      stage_cmd_q  <= JK_HOLD;
      stage_addr_q <= '0;
    end else begin
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      stage_vld_q  <= stage_vld_d;
      stage_cmd_q  <= stage_cmd_d;
      stage_addr_q <= stage_addr_d;
    end
  end

  // Cell bank and update report; reset drops any staged command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      upd_vld_q  <= 1'b0;
      upd_addr_q <= '0;
    end else begin
      q_q        <= q_d;
      upd_vld_q  <= upd_vld_d;
      upd_addr_q <= upd_addr_d;
    end
  end

  assign gnt      = gnt_q;
  assign upd_vld  = upd_vld_q;
  assign upd_addr = upd_addr_q;
  assign q        = q_q;
  assign q_bar    = ~q_q;

`ifdef JK_ARB_ASSERT_EN
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q))
    $info("gnt onehot0 ok");
    else $error("gnt not onehot0 at %0t", $time);

  a_gnt_no_repeat: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q & $past(gnt_q)) == '0)
    $info("gnt no-repeat ok");
    else $error("gnt bit high two cycles at %0t", $time);

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (upd_vld_q && $past(stage_cmd_q) == JK_HOLD) |->
      q_q[upd_addr_q] == $past(q_q[stage_addr_q]))
    $info("hold ok");
    else $error("hold update wrong at %0t", $time);

  a_reset: assert property (@(posedge clk) disable iff (!rst_n)
    (upd_vld_q && $past(stage_cmd_q) == JK_RESET) |-> !q_q[upd_addr_q])
    $info("reset ok");
    else $error("reset update wrong at %0t", $time);

  a_set: assert property (@(posedge clk) disable iff (!rst_n)
    (upd_vld_q && $past(stage_cmd_q) == JK_SET) |-> q_q[upd_addr_q])
    $info("set ok");
    else $error("set update wrong at %0t", $time);

  a_toggle: assert property (@(posedge clk) disable iff (!rst_n)
    (upd_vld_q && $past(stage_cmd_q) == JK_TOGGLE) |->
      q_q[upd_addr_q] != $past(q_q[stage_addr_q]))
    $info("toggle ok");
    else $error("toggle update wrong at %0t", $time);

  a_qbar: assert property (@(posedge clk) disable iff (!rst_n)
    q_bar == ~q)
    $info("q_bar ok");
    else $error("q_bar != ~q at %0t", $time);

  for (genvar g = 0; g < NREQ; g++) begin : g_live
    a_live: assert property (@(posedge clk) disable iff (!rst_n)
      (req[g] && !gnt_q[g]) |-> ##[1:NREQ+1] gnt_q[g])
      $info("req %0d granted", g);
      else $error("req %0d starved at %0t", g, $time);
  end
`endif

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
module tb_jk_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int NFF  = 8;
  localparam int AW   = $clog2(NFF);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   cmd;
  logic [AW*NREQ-1:0]  addr;
  logic [NREQ-1:0]     gnt;
  logic                upd_vld;
  logic [AW-1:0]       upd_addr;
  logic [NFF-1:0]      q;
  logic [NFF-1:0]      q_bar;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_cmd_arbiter #(.NREQ(NREQ), .NFF(NFF)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr),
    .gnt(gnt), .upd_vld(upd_vld), .upd_addr(upd_addr), .q(q), .q_bar(q_bar)
  );

  // Reference model: a queue of accepted-but-unapplied commands and a bit array.
  typedef struct packed {
    logic [1:0]    c;
    logic [AW-1:0] a;
  } pend_t;

  pend_t           pend[$];
  int              m_ptr;
  bit [NREQ-1:0]   m_gnt;
  bit [NFF-1:0]    m_q;
  bit              m_uv;
  logic [AW-1:0]   m_ua;

  task automatic m_reset();
    pend.delete();
    m_ptr = 0;
    m_gnt = '0;
    m_q   = '0;
    m_uv  = 1'b0;
    m_ua  = '0;
  endtask

  // Advance model and DUT by one clock; returns at the following negedge.
  task automatic tick();
    int    w;
    int    idx;
    pend_t p;
    m_uv = 1'b0;
    if (pend.size() > 0) begin
      p    = pend.pop_front();
      m_uv = 1'b1;
      m_ua = p.a;
      case (p.c)
        2'b01:   m_q[p.a] = 1'b0;
        2'b10:   m_q[p.a] = 1'b1;
        2'b11:   m_q[p.a] = ~m_q[p.a];
        default: ;
      endcase
    end
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (w < 0 && req[idx] && !m_gnt[idx]) w = idx;
    end
    m_gnt = '0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      p.c = cmd[2*w +: 2];
      p.a = addr[AW*w +: AW];
      pend.push_back(p);
      m_ptr = (w + 1) % NREQ;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input int a);
    req[i]          = 1'b1;
    cmd[2*i +: 2]   = c;
    addr[AW*i +: AW] = AW'(a);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar: got %h want ff", q_bar); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (upd_vld !== 1'b0) begin errors++; $display("FAIL reset_updvld: got %b want 0", upd_vld); end
    checks++; if (upd_addr !== 3'd0) begin errors++; $display("FAIL reset_updaddr: got %0d want 0", upd_addr); end
    rst_n = 1'b1;
    set_req(0, 2'b10, 1); tick();
    req = '0; tick();
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL reset_pre_q: got %h want 02", q); end
    set_req(0, 2'b10, 4); tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_pre_gnt: got %b want 0001", gnt); end
    rst_n = 1'b0;
    req   = '0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_mid_q: got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_mid_qbar: got %h want ff", q_bar); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_mid_gnt: got %b want 0000", gnt); end
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (upd_vld !== 1'b0) begin errors++; $display("FAIL reset_stray_upd: got %b want 0", upd_vld); end
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_stray_q: got %h want 00", q); end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 2'b10, 3); tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (upd_vld !== 1'b0) begin errors++; $display("FAIL single_early_upd: got %b want 0", upd_vld); end
    req = '0; tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse: got %b want 0000", gnt); end
    checks++; if (q !== 8'h08) begin errors++; $display("FAIL single_set_q: got %h want 08", q); end
    checks++; if (upd_vld !== 1'b1 || upd_addr !== 3'd3) begin errors++; $display("FAIL single_upd: got %b/%0d want 1/3", upd_vld, upd_addr); end
    set_req(0, 2'b01, 3); tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt2: got %b want 0001", gnt); end
    req = '0; tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL single_reset_q: got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL single_qbar: got %h want ff", q_bar); end
  endtask

  task automatic test_toggle_chain();
    do_reset();
    set_req(1, 2'b11, 5);
    set_req(2, 2'b11, 5);
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL tgl_gnt1: got %b want 0010", gnt); end
    req[1] = 1'b0; tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL tgl_gnt2: got %b want 0100", gnt); end
    checks++; if (q[5] !== 1'b1 || upd_vld !== 1'b1 || upd_addr !== 3'd5) begin errors++; $display("FAIL tgl_first: got q5=%b upd=%b/%0d want 1 1/5", q[5], upd_vld, upd_addr); end
    req = '0; tick();
    checks++; if (q !== 8'h00 || upd_vld !== 1'b1) begin errors++; $display("FAIL tgl_second: got q=%h upd=%b want 00 1", q, upd_vld); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, i + 1);
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (gnt !== exp_seq[n]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, gnt, exp_seq[n]); end
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL rr_q[%0d]: got %h want 00", n, q); end
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_hold_isolation();
    int cells [4];
    cells = '{0, 2, 5, 7};
    do_reset();
    for (int n = 0; n < 4; n++) begin
      set_req(0, 2'b10, cells[n]); tick();
      req = '0; tick();
    end
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL iso_setup: got %h want a5", q); end
    set_req(3, 2'b00, 0);
    set_req(0, 2'b11, 7);
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL iso_gnt3: got %b want 1000", gnt); end
    req[3] = 1'b0; tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL iso_gnt0: got %b want 0001", gnt); end
    checks++; if (q !== 8'hA5 || upd_vld !== 1'b1 || upd_addr !== 3'd0) begin errors++; $display("FAIL iso_hold: got q=%h upd=%b/%0d want a5 1/0", q, upd_vld, upd_addr); end
    req = '0; tick();
    checks++; if (q !== 8'h25 || upd_addr !== 3'd7) begin errors++; $display("FAIL iso_toggle: got q=%h addr=%0d want 25 7", q, upd_addr); end
    checks++; if (q_bar !== 8'hDA) begin errors++; $display("FAIL iso_qbar: got %h want da", q_bar); end
  endtask

  task automatic test_lone_persistent();
    bit exp_pat [6];
    exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    set_req(2, 2'b00, 6);
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++; if (gnt !== {1'b0, exp_pat[n], 2'b00}) begin errors++; $display("FAIL lone_gnt[%0d]: got %b want %b", n, gnt, {1'b0, exp_pat[n], 2'b00}); end
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else set_req(i, 2'($urandom), int'($urandom_range(NFF - 1, 0)));
        end else if (!req[i] && $urandom_range(99, 0) < 60) begin
          set_req(i, 2'($urandom), int'($urandom_range(NFF - 1, 0)));
        end
      end
      tick();
      checks++; if (gnt !== m_gnt) begin errors++; $display("FAIL rnd_gnt @%0d: got %b want %b", cyc, gnt, m_gnt); end
      checks++; if (upd_vld !== m_uv) begin errors++; $display("FAIL rnd_updvld @%0d: got %b want %b", cyc, upd_vld, m_uv); end
      if (m_uv) begin
        checks++; if (upd_addr !== m_ua) begin errors++; $display("FAIL rnd_updaddr @%0d: got %0d want %0d", cyc, upd_addr, m_ua); end
      end
      checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_q @%0d: got %h want %h", cyc, q, m_q); end
      checks++; if (q_bar !== ~m_q) begin errors++; $display("FAIL rnd_qbar @%0d: got %h want %h", cyc, q_bar, ~m_q); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    cmd   = '0;
    addr  = '0;
    m_reset();
    test_reset();
    test_single();
    test_toggle_chain();
    test_round_robin();
    test_hold_isolation();
    test_lone_persistent();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_arbiter.md
# jk_cmd_arbiter

- Shares a bank of NFF JK storage cells between NREQ requesters.
- Each requester posts a JK command (hold/reset/set/toggle) addressed to one cell.
- A round-robin arbiter grants one requester per cycle, and a registered apply stage performs the JK update on the addressed cell.
- Sits between the datapath's command sources and the JK state bank; the bank's q/q_bar vector is exported to downstream logic.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFF, 8, number of JK cells (2..32)
- AW, $clog2(NFF), cell address width (derived, not overridden)
- clk  input  1  sole clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- req  input  NREQ  request per requester, level
- cmd  input  2*NREQ  {j,k} per requester; requester i at bits [2i+1:2i]
- addr  input  AW*NREQ  target cell per requester; requester i at bits [AW*i+AW-1:AW*i]
- gnt  output  NREQ  registered one-hot grant pulse
- upd_vld  output  1  high the cycle after a cell update edge
- upd_addr  output  AW  cell updated at that edge
- q  output  NFF  JK cell states
- q_bar  output  NFF  always ~q

## Operation
- Arbitration, combinational at each posedge T:
  - Eligible set is req & ~gnt. A requester whose gnt is currently high is excluded, which prevents a double grant while it drops req.
  - Search starts at round-robin pointer ptr, ascending with wrap NREQ-1 -> 0.
  - First eligible index i wins.
- On a win at edge T:
  - gnt[i]=1 after T for exactly one cycle.
  - cmd_i and addr_i are captured into the stage register; stage_vld=1.
  - ptr <= (i+1) mod NREQ.
  - With no eligible requester: gnt=0, stage_vld=0, ptr unchanged.
- Apply at edge T+1 when stage_vld=1, on cell a=stage addr:
  - 00: q[a] holds.
  - 01: q[a]<=0.
  - 10: q[a]<=1.
  - 11: q[a]<=~q[a] (value before the edge).
  - Other cells are never modified.
- upd_vld/upd_addr are registered alongside the apply. A hold command still produces upd_vld.
- Requester handshake:
  - Keep req/cmd/addr stable until gnt seen high.
  - Then either drop req, or present the next command in the cycle after gnt.
  - A req that stays high is re-arbitrated from the cycle after gnt falls.
- Back-to-back updates to the same cell are serialized correctly. A toggle applied at T+1 followed by a toggle applied at T+2 yields the original value.
- Reset values (asynchronous assert, release synchronous to clk): gnt=0, stage_vld=0, upd_vld=0, upd_addr=0, q=0, q_bar=all ones, ptr=0.
- Reset mid-operation: a captured but unapplied command is discarded. No cell is updated by it after release.

## Timing
- Request to grant: gnt high the cycle after the first edge where the request wins.
- Grant to q update: q changes at the edge that ends the gnt cycle. The new value is visible while upd_vld=1.
- Throughput:
  - One command accepted per cycle across all requesters.
  - At most one per 2 cycles for any single requester.
- Fairness: with all NREQ requesters continuously requesting, each is granted exactly once in every NREQ consecutive grants.
- q_bar is combinationally ~q with no extra delay.

## Configuration
- JK_ARB_ASSERT_EN defined: concurrent SVA compiled in, clocked on posedge clk and disabled while !rst_n:
  - gnt is $onehot0.
  - No gnt bit stays high on two consecutive cycles.
  - For each of hold/reset/set/toggle, the addressed cell has the required value one cycle after the apply edge (toggle checked against $past).
  - q_bar==~q.
  - Every req held high is granted within NREQ+1 cycles.
  - Pass reported with $info, failure with $error carrying $time.
- JK_ARB_ASSERT_EN undefined: no assertion code. Functional RTL is identical.

## Test plan
- Reset: assert rst_n=0 mid-stream with a pending stage -> q=8'h00, q_bar=8'hFF, gnt=0; after release no stray upd_vld.
- Single requester: req=4'b0001, cmd0=10, addr0=3 -> gnt=0001 for one cycle, then q[3]=1, upd_vld=1, upd_addr=3. Then cmd0=01 -> q[3]=0.
- Toggle chain: requesters 1 and 2 both issue cmd=11 to addr=5, starting q[5]=0 -> grants 0010 then 0100 on consecutive cycles; q[5] goes 1 then 0.
- Round-robin: req=4'b1111 held, all cmd=00 -> gnt sequence 0001,0010,0100,1000,0001; q unchanged.
- Hold vs isolation: q=8'hA5, requester 3 cmd=00 addr=0 and requester 0 cmd=11 addr=7 -> q=8'h25, no other bits change.
- Lone persistent req: req=4'b0100 held 6 cycles -> gnt[2] pattern 1,0,1,0,1,0 (never two consecutive).
